// File: rtl/dpsram_be.sv
// dpsram_be: true dual-port synchronous RAM with per-lane write enables,
// selectable read-during-write behaviour and a built-in clear engine.
// Ports:
//   clk_i, rst_i (async active-low), ena_i (clock enable), clr_i (clear request)
//   A port: adr_i, dat_i, sel_i, wre_i -> dat_o (registered read data)
//   X port: xadr_i, xdat_i, xsel_i, xwre_i -> xdat_o (registered read data)
//   busy_o: clear sweep in progress; coll_o: same-address write pulse
module dpsram_be #(
  parameter int unsigned AW  = 5,
  parameter int unsigned DW  = 32,
  parameter int unsigned LW  = 8,
  parameter int unsigned RDW = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ena_i,
  input  logic                clr_i,
  input  logic [AW-1:0]       adr_i,
  input  logic [DW-1:0]       dat_i,
  input  logic [DW/LW-1:0]    sel_i,
  input  logic                wre_i,
  output logic [DW-1:0]       dat_o,
  input  logic [AW-1:0]       xadr_i,
  input  logic [DW-1:0]       xdat_i,
  input  logic [DW/LW-1:0]    xsel_i,
  input  logic                xwre_i,
  output logic [DW-1:0]       xdat_o,
  output logic                busy_o,
  output logic                coll_o
);

  localparam int unsigned NL    = DW / LW;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW-1:0]   xdat_q, xdat_d;
  logic            busy_q, busy_d;
  logic            coll_q, coll_d;

  logic [DW-1:0]   mem_q [DEPTH];

  logic            wa_c, wx_c, same_c;
  logic [DW-1:0]   mask_a_c, mask_x_c;
  logic [DW-1:0]   old_a_c, old_x_c;
  logic [DW-1:0]   wdat_a_c, wdat_x_c;
  logic [DW-1:0]   rd_a_c, rd_x_c;

  // Expand a lane-select vector into a per-bit mask.
  function automatic logic [DW-1:0] lane_mask(input logic [NL-1:0] sel);
    logic [DW-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < NL; k++) begin
      m[k*LW +: LW] = {LW{sel[k]}};
    end
    return m;
  endfunction

  // Write data and read-forwarding paths for both ports.
  always_comb begin
    wa_c     = (state_q == ST_IDLE) && ena_i && wre_i;
    wx_c     = (state_q == ST_IDLE) && ena_i && xwre_i;
    same_c   = (adr_i == xadr_i);
    mask_a_c = lane_mask(sel_i);
    mask_x_c = lane_mask(xsel_i);
    old_a_c  = mem_q[adr_i];
    old_x_c  = mem_q[xadr_i];

    wdat_x_c = (old_x_c & ~mask_x_c) | (xdat_i & mask_x_c);
    // On a same-address collision A's word already carries X's lanes, so A lanes win.
    if (wx_c && same_c) begin
      wdat_a_c = (wdat_x_c & ~mask_a_c) | (dat_i & mask_a_c);
    end else begin
      wdat_a_c = (old_a_c & ~mask_a_c) | (dat_i & mask_a_c);
    end

    rd_a_c = old_a_c;
    rd_x_c = old_x_c;
    if (RDW != 0) begin
      if (wa_c) begin
        rd_a_c = wdat_a_c;
      end else if (wx_c && same_c) begin
        rd_a_c = wdat_x_c;
      end
      if (wa_c && same_c) begin
        rd_x_c = wdat_a_c;
      end else if (wx_c) begin
        rd_x_c = wdat_x_c;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    xdat_d  = xdat_q;
    busy_d  = busy_q;
    coll_d  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        cnt_d  = cnt_q + AW'(1);
        dat_d  = '0;
        xdat_d = '0;
        busy_d = 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
        if (ena_i) begin
          dat_d  = rd_a_c;
          xdat_d = rd_x_c;
          coll_d = wa_c && wx_c && same_c;
        end
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      dat_q   <= '0;
      xdat_q  <= '0;
      busy_q  <= 1'b1;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      xdat_q  <= xdat_d;
      busy_q  <= busy_d;
      coll_q  <= coll_d;
    end
  end

  // Storage array; the clear sweep owns the write port while active.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wx_c && !(wa_c && same_c)) begin
        mem_q[xadr_i] <= wdat_x_c;
      end
      if (wa_c) begin
        mem_q[adr_i] <= wdat_a_c;
      end
    end
  end

  assign dat_o  = dat_q;
  assign xdat_o = xdat_q;
  assign busy_o = busy_q;
  assign coll_o = coll_q;

endmodule
